// File: rtl/prog_loader.sv
// Program loader: streams instruction words into memory,
// then hands memory and start PC to the CPU.
module prog_loader #(
  parameter logic [31:0] PC_BASE_ADDR = 32'h80020000,
  parameter int          DEPTH_WORDS  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        w_src_valid,
  input  logic [31:0] w_src_data_32,
  input  logic        w_src_last,
  output logic        w_src_ready,
  output logic [31:0] w_mem_addr_32,
  output logic [31:0] w_mem_data_in_32,
  output logic        w_mem_rw,
  output logic        w_mem_en,
  output logic [31:0] w_cpu_pc_32,
  output logic        w_cpu_run,
  output logic [12:0] w_word_count,
  output logic        w_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERROR
  } state_t;

  localparam logic [12:0] DEPTH_CNT = 13'(DEPTH_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [12:0] count;
  logic        accept;

  assign w_src_ready  = (state == LOAD) && (count < DEPTH_CNT);
  assign accept       = w_src_ready && w_src_valid;
  assign w_word_count = count;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        if (accept && w_src_last)
          state_nxt = DONE;
        else if (count == DEPTH_CNT)
          state_nxt = ERROR;
      end
      DONE:  if (start) state_nxt = LOAD;
      ERROR: if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      count            <= '0;
      w_overflow       <= 1'b0;
      w_cpu_run        <= 1'b0;
      w_mem_en         <= 1'b0;
      w_mem_rw         <= 1'b1;
      w_mem_addr_32    <= '0;
      w_mem_data_in_32 <= '0;
      w_cpu_pc_32      <= PC_BASE_ADDR;
    end else begin
      state       <= state_nxt;
      w_cpu_pc_32 <= PC_BASE_ADDR;
      w_overflow  <= (state_nxt == ERROR);
      w_cpu_run   <= (state == DONE) && !start;
      w_mem_en    <= 1'b0;
      w_mem_rw    <= 1'b1;
      if (state == DONE && !start) begin
        w_mem_en <= 1'b1;
      end
      if (state != LOAD && start) begin
        count <= '0;
      end
      if (accept) begin
        w_mem_en         <= 1'b1;
        w_mem_rw         <= 1'b0;
        w_mem_addr_32    <= {17'd0, count, 2'b00};
        w_mem_data_in_32 <= w_src_data_32;
        count            <= count + 13'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed scoreboard bench for prog_loader.
// Memory writes are matched against a queue of expected writes.
module tb_prog_loader;

  localparam int DEPTH = 4;
  localparam logic [31:0] PC = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        w_src_valid;
  logic [31:0] w_src_data_32;
  logic        w_src_last;
  logic        w_src_ready;
  logic [31:0] w_mem_addr_32;
  logic [31:0] w_mem_data_in_32;
  logic        w_mem_rw;
  logic        w_mem_en;
  logic [31:0] w_cpu_pc_32;
  logic        w_cpu_run;
  logic [12:0] w_word_count;
  logic        w_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;
  logic loading = 1'b0;
  logic [63:0] sb[$];
  int wtimes[$];

  prog_loader #(
    .PC_BASE_ADDR(PC),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .w_src_valid     (w_src_valid),
    .w_src_data_32   (w_src_data_32),
    .w_src_last      (w_src_last),
    .w_src_ready     (w_src_ready),
    .w_mem_addr_32   (w_mem_addr_32),
    .w_mem_data_in_32(w_mem_data_in_32),
    .w_mem_rw        (w_mem_rw),
    .w_mem_en        (w_mem_en),
    .w_cpu_pc_32     (w_cpu_pc_32),
    .w_cpu_run       (w_cpu_run),
    .w_word_count    (w_word_count),
    .w_overflow      (w_overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard
  always @(negedge clock) begin
    if (w_mem_en === 1'b1 && w_mem_rw === 1'b0) begin
      logic [63:0] e;
      wtimes.push_back(cyc);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: got %h/%h expected none",
               w_mem_addr_32, w_mem_data_in_32);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", w_mem_addr_32, e[63:32]);
        chk("wr_data", w_mem_data_in_32, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    model_cnt = 0;
    loading = 1'b1;
    wtimes.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic l,
                      input logic v);
    logic exp_rdy;
    @(negedge clock);
    w_src_valid = v;
    w_src_data_32 = d;
    w_src_last = l;
    #1;
    exp_rdy = loading && (model_cnt < DEPTH);
    chk("src_ready", {31'd0, w_src_ready}, {31'd0, exp_rdy});
    if (v && exp_rdy) begin
      sb.push_back({32'(model_cnt * 4), d});
      model_cnt++;
      if (l) loading = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clock);
    w_src_valid = 1'b0;
    w_src_last = 1'b0;
  endtask

  task automatic wait_run();
    for (int k = 0; k < 10 && w_cpu_run !== 1'b1; k++)
      @(negedge clock);
    chk("cpu_run_wait", {31'd0, w_cpu_run}, 32'd1);
  endtask

  task automatic wait_ovf();
    for (int k = 0; k < 10 && w_overflow !== 1'b1; k++)
      @(negedge clock);
    chk("overflow_wait", {31'd0, w_overflow}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, {31'd0, w_mem_en}, 32'd0);
    chk({tag, "_rw"}, {31'd0, w_mem_rw}, 32'd1);
    chk({tag, "_addr"}, w_mem_addr_32, 32'd0);
    chk({tag, "_data"}, w_mem_data_in_32, 32'd0);
    chk({tag, "_cnt"}, {19'd0, w_word_count}, 32'd0);
    chk({tag, "_run"}, {31'd0, w_cpu_run}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, w_overflow}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, w_src_ready}, 32'd0);
    chk({tag, "_pc"}, w_cpu_pc_32, PC);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    w_src_valid = 1'b0;
    w_src_data_32 = '0;
    w_src_last = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    reset = 1'b1;

    // Three back-to-back words
    pulse_start();
    send(32'h20080005, 1'b0, 1'b1);
    send(32'h20090007, 1'b0, 1'b1);
    send(32'h01095020, 1'b1, 1'b1);
    idle();
    wait_run();
    chk("b2b_nwr", wtimes.size(), 32'd3);
    if (wtimes.size() == 3) begin
      chk("b2b_gap1", wtimes[1] - wtimes[0], 32'd1);
      chk("b2b_gap2", wtimes[2] - wtimes[1], 32'd1);
    end
    chk("done_cnt", {19'd0, w_word_count}, 32'd3);
    chk("done_pc", w_cpu_pc_32, PC);
    chk("done_rw", {31'd0, w_mem_rw}, 32'd1);
    chk("done_en", {31'd0, w_mem_en}, 32'd1);
    chk("done_ovf", {31'd0, w_overflow}, 32'd0);
    chk("done_sb", sb.size(), 32'd0);

    // Restart from DONE, valid toggling, stray last ignored
    pulse_start();
    chk("rst_run", {31'd0, w_cpu_run}, 32'd0);
    chk("rst_cnt", {19'd0, w_word_count}, 32'd0);
    send(32'hAAAA0001, 1'b0, 1'b1);
    send(32'hBBBB0002, 1'b1, 1'b0);
    send(32'hCCCC0003, 1'b1, 1'b1);
    idle();
    wait_run();
    chk("tog_nwr", wtimes.size(), 32'd2);
    if (wtimes.size() == 2)
      chk("tog_gap", wtimes[1] - wtimes[0], 32'd2);
    chk("tog_cnt", {19'd0, w_word_count}, 32'd2);

    // Overflow: five words, no last
    pulse_start();
    for (int i = 0; i < 5; i++)
      send(32'h11110000 + 32'(i), 1'b0, 1'b1);
    idle();
    wait_ovf();
    chk("ovf_nwr", wtimes.size(), 32'd4);
    chk("ovf_run", {31'd0, w_cpu_run}, 32'd0);
    chk("ovf_en", {31'd0, w_mem_en}, 32'd0);
    chk("ovf_rdy", {31'd0, w_src_ready}, 32'd0);
    chk("ovf_cnt", {19'd0, w_word_count}, 32'd4);
    chk("ovf_sb", sb.size(), 32'd0);

    // Restart from ERROR; exact fit with last on final slot
    pulse_start();
    chk("err_clr", {31'd0, w_overflow}, 32'd0);
    for (int i = 0; i < 4; i++)
      send(32'h22220000 + 32'(i), (i == 3), 1'b1);
    idle();
    wait_run();
    chk("fit_ovf", {31'd0, w_overflow}, 32'd0);
    chk("fit_cnt", {19'd0, w_word_count}, 32'd4);
    chk("fit_nwr", wtimes.size(), 32'd4);

    // Reset mid-load, coinciding with a further accept
    pulse_start();
    send(32'h33330000, 1'b0, 1'b1);
    send(32'h33330001, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    w_src_data_32 = 32'h33330002;
    loading = 1'b0;
    @(negedge clock);
    chk_reset_vals("mid");
    reset = 1'b1;
    w_src_valid = 1'b0;
    pulse_start();
    send(32'h44440000, 1'b1, 1'b1);
    idle();
    wait_run();
    chk("rl_cnt", {19'd0, w_word_count}, 32'd1);
    chk("rl_sb", sb.size(), 32'd0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter PC_BASE_ADDR, default 32'h80020000, meaning the byte address of instruction word 0 and the CPU start PC.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning instruction memory capacity in 32-bit words (power of two, 2..4096).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin (or restart) a program load.
REQ-006 SHALL have port w_src_valid  input  1  source word available.
REQ-007 SHALL have port w_src_data_32  input  32  instruction word from source.
REQ-008 SHALL have port w_src_last  input  1  qualifies final word of program.
REQ-009 SHALL have port w_src_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port w_mem_addr_32  output  32  byte offset into instruction memory.
REQ-011 SHALL have port w_mem_data_in_32  output  32  write data to instruction memory.
REQ-012 SHALL have port w_mem_rw  output  1  0 = write, 1 = read.
REQ-013 SHALL have port w_mem_en  output  1  memory enable.
REQ-014 SHALL have port w_cpu_pc_32  output  32  start PC for fetch.
REQ-015 SHALL have port w_cpu_run  output  1  fetch may proceed; memory handed to CPU.
REQ-016 SHALL have port w_word_count  output  13  words written in current load.
REQ-017 SHALL have port w_overflow  output  1  program exceeded DEPTH_WORDS.

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE, ERROR; all outputs registered except w_src_ready, which is a decode of state and count.
REQ-019 IDLE: w_src_ready=0, w_mem_en=0, w_mem_rw=1, w_cpu_run=0; start=1 -> LOAD with w_word_count cleared.
REQ-020 LOAD: w_src_ready=1 while w_word_count < DEPTH_WORDS; a word is accepted on a cycle with w_src_valid & w_src_ready.
REQ-021 Accept in cycle N SHALL produce, in cycle N+1 only, w_mem_en=1, w_mem_rw=0, w_mem_addr_32 = 4*count_at_N, w_mem_data_in_32 = accepted word; w_word_count increments by 1 at the same edge.
REQ-022 Cycles in LOAD without accept SHALL drive w_mem_en=0 (no write); back-to-back accepts SHALL write every cycle, no bubbles.
REQ-023 Accepted word with w_src_last=1 SHALL be written per REQ-021, then state -> DONE at that same edge; w_src_last without w_src_valid SHALL be ignored.
REQ-024 w_word_count reaching DEPTH_WORDS without last SHALL deassert w_src_ready and move to ERROR on the next edge; the DEPTH_WORDS-th word is still written.
REQ-025 Word accepted exactly at the last slot with w_src_last=1 SHALL go to DONE, not ERROR.
REQ-026 DONE: w_mem_en=1, w_mem_rw=1, w_cpu_pc_32=PC_BASE_ADDR, w_cpu_run=1, w_src_ready=0; w_word_count held.
REQ-027 ERROR: w_overflow=1, w_cpu_run=0, w_mem_en=0, w_src_ready=0.
REQ-028 start=1 in DONE or ERROR SHALL return to LOAD next edge, clearing w_word_count and w_overflow and dropping w_cpu_run in that same edge; start in LOAD SHALL be ignored.
REQ-029 w_mem_addr_32 SHALL be zero-extended 4*count, never wrapping; w_cpu_pc_32 = PC_BASE_ADDR in all states.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, w_word_count=0, w_overflow=0, w_cpu_run=0, w_mem_en=0, w_mem_rw=1, w_mem_addr_32=0, w_mem_data_in_32=0, regardless of state or in-flight write.
REQ-031 A write scheduled per REQ-021 coinciding with reset SHALL be dropped (w_mem_en=0).

Verification
REQ-032 Load 3 words 0x20080005, 0x20090007, 0x01095020 (last on third), back-to-back -> writes at offsets 0x0, 0x4, 0x8 on consecutive cycles; DONE with w_word_count=3, w_cpu_run=1, w_cpu_pc_32=0x80020000, w_mem_rw=1.
REQ-033 Source valid toggling 1,0,1 -> exactly 2 write cycles with a gap, addresses 0x0 then 0x4.
REQ-034 DEPTH_WORDS=4, 5 words without last -> 4 writes (last at 0xC), w_src_ready=0, w_overflow=1, w_cpu_run=0.
REQ-035 DEPTH_WORDS=4, 4th word with last -> DONE, w_overflow=0.
REQ-036 reset=0 mid-LOAD after 2 accepts -> all outputs at REQ-030 values next cycle; subsequent start reloads from offset 0x0.
REQ-037 start in DONE -> w_cpu_run=0 next cycle, w_word_count=0, new load overwrites from 0x0.
